// File: rtl/clock_generator.sv
// Programmable clock divider: registered, glitch-free clk_out with single-cycle
// rise/fall strobes; the divide ratio only changes at period boundaries.
module clock_generator #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic                 clk_out,
  output logic                 rise_tick,
  output logic                 fall_tick,
  output logic [DIV_WIDTH-1:0] div_active,
  output logic                 running
);

  // state  | meaning
  // S_IDLE | no periods generated; a non-zero ratio with enable starts one
  // S_RUN  | producing periods; cnt walks 0..N-1, boundary at N-1
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO     = DIV_WIDTH'(2);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div_active;
  logic [DIV_WIDTH-1:0] r_pend_val;
  logic                 r_pend_flag;
  logic                 r_clk_out;
  logic                 r_rise;
  logic                 r_fall;

  logic [DIV_WIDTH-1:0] w_load_val;
  logic [DIV_WIDTH-1:0] w_sel_ratio;
  logic                 w_boundary;
  logic                 w_go;
  logic [DIV_WIDTH:0]   w_cnt_inc;
  logic [DIV_WIDTH:0]   w_high;

  logic [DIV_WIDTH-1:0] w_cnt_nxt;
  logic [DIV_WIDTH-1:0] w_div_active_nxt;
  logic [DIV_WIDTH-1:0] w_pend_val_nxt;
  logic                 w_pend_flag_nxt;
  logic                 w_clk_out_nxt;
  logic                 w_rise_nxt;
  logic                 w_fall_nxt;

  // A load on the same edge outranks anything pending, so it governs the new period.
  assign w_load_val  = (div_value == ONE) ? TWO : div_value;
  assign w_sel_ratio = div_load ? w_load_val : (r_pend_flag ? r_pend_val : r_div_active);
  assign w_go        = enable && (w_sel_ratio != '0);
  assign w_boundary  = (r_cnt == r_div_active - ONE);
  assign w_cnt_inc   = {1'b0, r_cnt} + {{DIV_WIDTH{1'b0}}, 1'b1};
  assign w_high      = ({1'b0, r_div_active} + {{DIV_WIDTH{1'b0}}, 1'b1}) >> 1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_div_active <= DEF_DIV;
      r_pend_val   <= '0;
      r_pend_flag  <= 1'b0;
      r_clk_out    <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_div_active <= w_div_active_nxt;
      r_pend_val   <= w_pend_val_nxt;
      r_pend_flag  <= w_pend_flag_nxt;
      r_clk_out    <= w_clk_out_nxt;
      r_rise       <= w_rise_nxt;
      r_fall       <= w_fall_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_nxt = S_RUN;
      S_RUN:   if (w_boundary && !w_go) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt        = r_cnt;
    w_div_active_nxt = r_div_active;
    w_pend_val_nxt   = r_pend_val;
    w_pend_flag_nxt  = r_pend_flag;
    w_clk_out_nxt    = 1'b0;
    w_rise_nxt       = 1'b0;
    w_fall_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_active_nxt = w_sel_ratio;
        w_pend_flag_nxt  = 1'b0;
        w_cnt_nxt        = '0;
        if (w_go) begin
          w_clk_out_nxt = 1'b1;
          w_rise_nxt    = 1'b1;
        end
      end
      S_RUN: begin
        if (w_boundary) begin
          w_div_active_nxt = w_sel_ratio;
          w_pend_flag_nxt  = 1'b0;
          w_cnt_nxt        = '0;
          if (w_go) begin
            w_clk_out_nxt = 1'b1;
            w_rise_nxt    = 1'b1;
          end
        end else begin
          w_cnt_nxt     = w_cnt_inc[DIV_WIDTH-1:0];
          w_clk_out_nxt = (w_cnt_inc < w_high);
          w_fall_nxt    = (w_cnt_inc == w_high);
          if (div_load) begin
            w_pend_val_nxt  = w_load_val;
            w_pend_flag_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign clk_out    = r_clk_out;
  assign rise_tick  = r_rise;
  assign fall_tick  = r_fall;
  assign div_active = r_div_active;
  assign running    = (r_state == S_RUN);

endmodule

// File: tb/tb_clock_generator.sv
// Directed bench for clock_generator: each step pushes the expected outputs
// for the coming edge to a scoreboard, which is popped and checked after it.
module tb_clock_generator;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       div_load;
  logic [7:0] div_value;
  logic       clk_out;
  logic       rise_tick;
  logic       fall_tick;
  logic [7:0] div_active;
  logic       running;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] bits;   // {clk_out, rise_tick, fall_tick, running}
    logic [7:0] dact;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  clock_generator #(.DIV_WIDTH(8), .DEFAULT_DIV(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .div_load   (div_load),
    .div_value  (div_value),
    .clk_out    (clk_out),
    .rise_tick  (rise_tick),
    .fall_tick  (fall_tick),
    .div_active (div_active),
    .running    (running)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check_out();
    exp_t e;
    logic [3:0] got;
    n_checks++;
    assert (sb_q.size() > 0) else begin
      n_errors++;
      $error("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e   = sb_q.pop_front();
    got = {clk_out, rise_tick, fall_tick, running};
    n_checks++;
    assert (got === e.bits) else begin
      n_errors++;
      $error("FAIL %s {clk,rise,fall,run}: got %b expected %b", e.tag, got, e.bits);
    end
    n_checks++;
    assert (div_active === e.dact) else begin
      n_errors++;
      $error("FAIL %s div_active: got %0d expected %0d", e.tag, div_active, e.dact);
    end
    n_checks++;
    assert (!(rise_tick === 1'b1 && fall_tick === 1'b1)) else begin
      n_errors++;
      $error("FAIL %s tick_overlap: got rise=%b fall=%b expected not both 1", e.tag, rise_tick, fall_tick);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic ld, input logic [7:0] dv,
                      input logic [3:0] exp_bits, input logic [7:0] exp_dact, input string tag);
    exp_t e;
    reset     = rst;
    enable    = en;
    div_load  = ld;
    div_value = dv;
    e.bits = exp_bits;
    e.dact = exp_dact;
    e.tag  = tag;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; div_load = 1'b0; div_value = 8'd0;
    #2;
    // bits: {clk_out, rise_tick, fall_tick, running}
    step(1, 0, 0, 0, 4'b0000, 8'd2, "reset0");
    step(1, 1, 0, 0, 4'b0000, 8'd2, "reset1");

    // default N=2 straight out of reset
    step(0, 1, 0, 0, 4'b1101, 8'd2, "n2_r0");
    step(0, 1, 0, 0, 4'b0011, 8'd2, "n2_f0");
    step(0, 1, 0, 0, 4'b1101, 8'd2, "n2_r1");
    step(0, 1, 0, 0, 4'b0011, 8'd2, "n2_f1");
    step(0, 1, 0, 0, 4'b1101, 8'd2, "n2_r2");
    step(0, 1, 0, 0, 4'b0011, 8'd2, "n2_f2");
    step(0, 0, 0, 0, 4'b0000, 8'd2, "n2_stop");

    // load N=5 while idle, then run two periods
    step(0, 0, 1, 5, 4'b0000, 8'd5, "idle_ld5");
    for (int p = 0; p < 2; p++) begin
      step(0, 1, 0, 0, 4'b1101, 8'd5, "n5_o0");
      step(0, 1, 0, 0, 4'b1001, 8'd5, "n5_o1");
      step(0, 1, 0, 0, 4'b1001, 8'd5, "n5_o2");
      step(0, 1, 0, 0, 4'b0011, 8'd5, "n5_o3");
      step(0, 1, 0, 0, 4'b0001, 8'd5, "n5_o4");
    end

    // load on the boundary edge governs the period starting there
    step(0, 1, 1, 4, 4'b1101, 8'd4, "bnd_ld4");
    step(0, 1, 0, 0, 4'b1001, 8'd4, "n4_o1");
    step(0, 1, 1, 6, 4'b0011, 8'd4, "n4_ld6_o2");
    step(0, 1, 0, 0, 4'b0001, 8'd4, "n4_o3");
    step(0, 1, 0, 0, 4'b1101, 8'd6, "n6_o0");
    step(0, 1, 0, 0, 4'b1001, 8'd6, "n6_o1");
    step(0, 1, 0, 0, 4'b1001, 8'd6, "n6_o2");
    step(0, 1, 0, 0, 4'b0011, 8'd6, "n6_o3");
    step(0, 1, 0, 0, 4'b0001, 8'd6, "n6_o4");
    step(0, 1, 0, 0, 4'b0001, 8'd6, "n6_o5");
    step(0, 1, 1, 4, 4'b1101, 8'd4, "bnd_ld4b");

    // drop enable at offset 0: period completes, then stops
    step(0, 0, 0, 0, 4'b1001, 8'd4, "dis_o1");
    step(0, 0, 0, 0, 4'b0011, 8'd4, "dis_o2");
    step(0, 0, 0, 0, 4'b0001, 8'd4, "dis_o3");
    step(0, 0, 0, 0, 4'b0000, 8'd4, "dis_stop");
    step(0, 0, 0, 0, 4'b0000, 8'd4, "dis_idle");
    step(0, 1, 0, 0, 4'b1101, 8'd4, "reen");

    // value 1 coerced to 2; value 0 stops at the boundary
    step(0, 1, 1, 1, 4'b1001, 8'd4, "ld1_o1");
    step(0, 1, 0, 0, 4'b0011, 8'd4, "ld1_o2");
    step(0, 1, 0, 0, 4'b0001, 8'd4, "ld1_o3");
    step(0, 1, 0, 0, 4'b1101, 8'd2, "coerce2");
    step(0, 1, 1, 0, 4'b0011, 8'd2, "ld0_o1");
    step(0, 1, 0, 0, 4'b0000, 8'd0, "ld0_stop");
    step(0, 1, 0, 0, 4'b0000, 8'd0, "zero_idle");
    step(0, 1, 1, 3, 4'b1101, 8'd3, "ld3_start");
    step(0, 1, 0, 0, 4'b1001, 8'd3, "n3_o1");
    step(0, 1, 0, 0, 4'b0011, 8'd3, "n3_o2");
    step(0, 1, 0, 0, 4'b1101, 8'd3, "n3_r");

    // several loads before a boundary: last one wins
    step(0, 1, 1, 7, 4'b1001, 8'd3, "lw_ld7");
    step(0, 1, 1, 5, 4'b0011, 8'd3, "lw_ld5");
    step(0, 1, 0, 0, 4'b1101, 8'd5, "lw_n5");
    step(0, 1, 0, 0, 4'b1001, 8'd5, "lw_o1");
    step(0, 1, 0, 0, 4'b1001, 8'd5, "lw_o2");
    step(0, 1, 0, 0, 4'b0011, 8'd5, "lw_o3");
    step(0, 1, 0, 0, 4'b0001, 8'd5, "lw_o4");

    // N=8, reset mid-high-phase, then restart at default ratio
    step(0, 1, 1, 8, 4'b1101, 8'd8, "n8_o0");
    step(0, 1, 0, 0, 4'b1001, 8'd8, "n8_o1");
    step(0, 1, 0, 0, 4'b1001, 8'd8, "n8_o2");
    step(1, 1, 0, 0, 4'b0000, 8'd2, "mid_reset");
    step(0, 1, 0, 0, 4'b1101, 8'd2, "post_r0");
    step(0, 1, 0, 0, 4'b0011, 8'd2, "post_f0");
    step(0, 1, 0, 0, 4'b1101, 8'd2, "post_r1");

    n_checks++;
    assert (sb_q.size() == 0) else begin
      n_errors++;
      $error("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
